// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of one registered output slot.
// Captures the winning requester's word and holds it until accepted.
module rr_mux_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int STALL_MAX = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] d,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       y,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                busy,
    output logic                stall_err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(STALL_MAX + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    stall_cnt;
    logic [N_REQ-1:0] elig;
    logic             win_found;
    logic [PW-1:0]    win;
    logic [DW-1:0]    win_data;
    logic [N_REQ-1:0] win_oh;
    logic             slot_free;
    logic             stalled;

    assign y_valid   = (state == HOLD);
    assign busy      = y_valid;
    assign slot_free = (state == IDLE) || y_ready;
    assign stalled   = (state == HOLD) && !y_ready;

    // A requester granted last edge still shows its old req/d, so mask it.
    assign elig = req & ~gnt;

    // Scan ptr+1 .. ptr (wrapping) for the first eligible requester.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win       = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win       = PW'(idx);
            end
        end
    end

    // Word and one-hot grant of the current winner.
    always_comb begin
        win_data = d[int'(win)*DW +: DW];
        win_oh   = N_REQ'(1) << win;
    end

    // Slot FSM: capture on a free slot, otherwise hold the pending word.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= IDLE;
            gnt   <= '0;
            y     <= '0;
            ptr   <= PW'(N_REQ - 1);
        end else if (slot_free) begin
            if (win_found) begin
                state <= HOLD;
                y     <= win_data;
                gnt   <= win_oh;
                ptr   <= win;
            end else begin
                state <= IDLE;
                gnt   <= '0;
            end
        end else begin
            gnt <= '0;
        end
    end

    // Watchdog: count consecutive stalls, latch the flag until reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (stalled) begin
            if (stall_cnt == CW'(STALL_MAX - 1)) begin
                stall_err <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed literal checks plus a randomized run
// compared every cycle against a behavioural slot model.
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SM = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*DW-1:0] d;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   y;
    logic            y_valid;
    logic            y_ready;
    logic            busy;
    logic            stall_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state
    bit         m_valid;
    logic [7:0] m_y;
    int         m_gi;
    int         m_ptr;
    int         m_cnt;
    bit         m_err;

    rr_mux_arbiter #(.N_REQ(N), .DW(DW), .STALL_MAX(SM)) dut (
        .clk(clk), .rstn(rstn), .req(req), .d(d), .gnt(gnt), .y(y),
        .y_valid(y_valid), .y_ready(y_ready), .busy(busy),
        .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: one registered slot, rotating priority.
    always @(posedge clk) begin
        int win;
        int idx;
        if (rstn) begin
            m_valid = 0; m_y = 0; m_gi = -1;
            m_ptr = N - 1; m_cnt = 0; m_err = 0;
        end else begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && req[idx] && idx != m_gi) win = idx;
            end
            if (m_valid && !y_ready) begin
                if (m_cnt >= SM - 1) m_err = 1;
                m_cnt++;
                m_gi = -1;
            end else begin
                m_cnt = 0;
                if (win >= 0) begin
                    m_y = d[win*DW +: DW];
                    m_valid = 1;
                    m_gi = win;
                    m_ptr = win;
                end else begin
                    m_valid = 0;
                    m_gi = -1;
                end
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (chk_en) begin
            eg = (m_gi < 0) ? '0 : (N'(1) << m_gi);
            chk("m_gnt", 32'(gnt), 32'(eg));
            chk("m_y", 32'(y), 32'(m_y));
            chk("m_valid", 32'(y_valid), 32'(m_valid));
            chk("m_busy", 32'(busy), 32'(m_valid));
            chk("m_err", 32'(stall_err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        cyc();
        rstn = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 32'h0);
        chk({nm, "_valid"}, 32'(y_valid), 32'h0);
        chk({nm, "_y"}, 32'(y), 32'h0);
        chk({nm, "_busy"}, 32'(busy), 32'h0);
        chk({nm, "_err"}, 32'(stall_err), 32'h0);
    endtask

    int stall_run;

    initial begin
        rstn = 1'b1; req = '0; d = '0; y_ready = 1'b0;
        cyc();
        chk_en = 1'b1;
        chk_idle("rst1");
        cyc();
        chk_idle("rst2");
        rstn = 1'b0;
        cyc();
        chk_idle("idle");

        // single requester
        req = 4'b0100; d[2*DW +: DW] = 8'h5A; y_ready = 1'b1;
        cyc();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_y", 32'(y), 32'h5A);
        chk("single_valid", 32'(y_valid), 32'h1);
        req = '0;
        cyc();
        chk("single_gnt0", 32'(gnt), 32'h0);
        chk("single_drop", 32'(y_valid), 32'h0);
        chk("single_keep_y", 32'(y), 32'h5A);

        // fairness from reset pointer
        do_reset();
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 8'(8'h10 + i);
        req = 4'b1111; y_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            chk("rr_y", 32'(y), 32'(8'h10 + k % 4));
        end
        req = '0;
        cyc();

        // backpressure then same-edge accept and capture
        do_reset();
        req = 4'b0011; d[0 +: DW] = 8'hA0; d[DW +: DW] = 8'hA1;
        y_ready = 1'b0;
        cyc();
        chk("bp_cap_gnt", 32'(gnt), 32'h1);
        chk("bp_cap_y", 32'(y), 32'hA0);
        req = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_hold_gnt", 32'(gnt), 32'h0);
            chk("bp_hold_y", 32'(y), 32'hA0);
            chk("bp_hold_v", 32'(y_valid), 32'h1);
        end
        y_ready = 1'b1;
        cyc();
        chk("bp_b2b_gnt", 32'(gnt), 32'h2);
        chk("bp_b2b_y", 32'(y), 32'hA1);
        chk("bp_b2b_v", 32'(y_valid), 32'h1);
        req = '0;
        cyc();
        chk("bp_end_v", 32'(y_valid), 32'h0);

        // watchdog fires on the 16th stalled edge
        do_reset();
        req = 4'b0001; d[0 +: DW] = 8'h77; y_ready = 1'b0;
        cyc();
        req = '0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk("wd_pre", 32'(stall_err), 32'h0);
        end
        cyc();
        chk("wd_fire", 32'(stall_err), 32'h1);
        y_ready = 1'b1;
        cyc();
        chk("wd_sticky_v", 32'(y_valid), 32'h0);
        chk("wd_sticky", 32'(stall_err), 32'h1);
        cyc();
        chk("wd_sticky2", 32'(stall_err), 32'h1);

        // 15 stalls then accept: no flag
        do_reset();
        req = 4'b0001; y_ready = 1'b0;
        cyc();
        req = '0;
        for (int k = 0; k < 15; k++) cyc();
        y_ready = 1'b1;
        cyc();
        chk("wd_15_err", 32'(stall_err), 32'h0);
        chk("wd_15_v", 32'(y_valid), 32'h0);
        cyc();
        chk("wd_15_err2", 32'(stall_err), 32'h0);

        // reset mid-transfer, then pointer back at N-1
        req = 4'b1000; d[3*DW +: DW] = 8'h33; y_ready = 1'b0;
        cyc();
        chk("mid_v", 32'(y_valid), 32'h1);
        rstn = 1'b1;
        cyc();
        chk_idle("mid_rst");
        rstn = 1'b0; req = 4'b1001; d[0 +: DW] = 8'h01; y_ready = 1'b1;
        cyc();
        chk("mid_g0", 32'(gnt), 32'h1);
        chk("mid_y0", 32'(y), 32'h01);
        cyc();
        chk("mid_g3", 32'(gnt), 32'h8);
        chk("mid_y3", 32'(y), 32'h33);
        req = '0;
        cyc();

        // randomized traffic with backpressure bursts and resets
        stall_run = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && m_gi == i) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    d[i*DW +: DW] = 8'($urandom);
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    d[i*DW +: DW] = 8'($urandom);
                end
            end
            if (stall_run > 0) begin
                stall_run--;
                y_ready = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                stall_run = $urandom_range(10, 22);
                y_ready = 1'b0;
            end else begin
                y_ready = ($urandom_range(0, 3) != 0);
            end
            rstn = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin controller that shares one registered 8-bit output channel (y / y_valid / y_ready) among N_REQ requesters, each presenting a request and an 8-bit data word.
- It replaces ad-hoc sel-driven muxing: the arbiter owns the select, captures the winning word into a register and holds it until the consumer accepts it.
- A stall watchdog flags a consumer that stops accepting data.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width per requester and of y.
- STALL_MAX, 16, consecutive stalled cycles (y_valid=1, y_ready=0) that set stall_err.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous reset, active-high (asserted = 1; port name per codebase convention).
- req  in  N_REQ  per-requester "word available"; held high until granted.
- d  in  N_REQ*DW  flattened data; requester i occupies bits [i*DW +: DW].
- gnt  out  N_REQ  registered one-hot grant pulse, one cycle per captured word.
- y  out  DW  registered output word.
- y_valid  out  1  y holds an unaccepted word.
- y_ready  in  1  consumer accepts y when y_valid&y_ready at a clock edge.
- busy  out  1  equals y_valid (slot occupied).
- stall_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rstn=1 at an edge): gnt=0, y=0, y_valid=0, busy=0, stall_err=0, ptr=N_REQ-1, stall_cnt=0. Reset mid-transfer drops any pending word without a handshake.
- The FSM has two states.
  - IDLE: y_valid=0.
  - HOLD: y_valid=1.
- A slot is free in a cycle when state=IDLE, or when state=HOLD and y_ready=1.
- Eligible set = req & ~gnt. A requester pulsed gnt this cycle is masked, because it updates req/d only at the next edge.
- Winner: first eligible index scanning ptr+1, ptr+2, … modulo N_REQ, including ptr itself last.
- Slot free and eligible set non-empty at an edge:
  - y<=d[winner], y_valid<=1, gnt<=onehot(winner), ptr<=winner.
  - Next state is HOLD.
  - Back-to-back transfer: an accept and a new capture occur on the same edge, giving 1 word/cycle aggregate throughput.
- Slot free and eligible set empty: y_valid<=0, gnt<=0, next state IDLE, y keeps its last value.
- Slot not free (HOLD, y_ready=0): y and y_valid hold, gnt<=0, no arbitration, ptr holds.
- Latency: req rising in IDLE produces gnt and y_valid at the next edge (1 cycle). d is sampled on that same edge.
- Per-requester maximum rate is one word every 2 cycles because of the gnt mask.
- Fairness: with all N_REQ requesting continuously, each is granted exactly once per N_REQ consecutive grants.
- Watchdog:
  - stall_cnt increments each cycle with y_valid=1 and y_ready=0, and clears otherwise.
  - When stall_cnt reaches STALL_MAX-1 while still stalled, stall_err<=1.
  - stall_err stays 1 until reset. It never blocks operation.
  - stall_cnt saturates.
- All outputs are registered, with no combinational path from req/d/y_ready to outputs. Every state/output is assigned on every path, so no latches are inferred.
- y_ready while y_valid=0 is ignored.

Test Plan:
- Reset/idle: hold rstn=1 for 2 cycles, then req=0 → gnt=0, y_valid=0, y=0, busy=0, stall_err=0 throughout.
- Single requester: req=4'b0100, d[2]=8'h5A, y_ready=1 → next edge gnt=4'b0100 for 1 cycle, y=8'h5A, y_valid=1. If req drops after gnt, y_valid=0 the edge after.
- Round-robin fairness: req=4'b1111 held, d[i]=8'h10+i, y_ready=1 → grant order 0,1,2,3,0,1… and y sequence 10,11,12,13,10…. Each gnt is one cycle wide and no requester is granted twice in consecutive cycles.
- Backpressure: req=4'b0011, y_ready=0 for 5 cycles after the first capture → y=d[0] and y_valid=1 held, gnt=0, ptr frozen. y_ready=1 then yields an accept plus same-edge capture of d[1], with gnt=4'b0010.
- Watchdog: y_valid=1 with y_ready=0 for 16 cycles (STALL_MAX=16) → stall_err rises at the 16th stalled edge and stays 1 after y_ready=1. stall_err does not rise after 15 stalled cycles followed by one accept.
- Reset mid-operation: assert rstn while y_valid=1 and req=4'b1000 → next edge all outputs 0 and ptr=3. After release, requester 0 is preferred if req=4'b1001 (grant 0, then 3).
